// File: rtl/id_stage_pipelined.sv
// Decode stage: register file, immediate/branch-target decode, operand forwarding,
// load-use bubble and registered ID/EX boundary. Optional macro: ID_WRITE_BYPASS_EN.
module id_stage_pipelined #(
   parameter int DATA_W   = 64,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       instr_d,
   input  logic [DATA_W-1:0] pc_d,
   input  logic              valid_d,
   input  logic              reg2loc_d,
   input  logic              uncond_br_d,
   input  logic              mem_read_d,
   input  logic              reg_write_w,
   input  logic [4:0]        rd_w,
   input  logic [DATA_W-1:0] wdata_w,
   input  logic [1:0]        fwd_a,
   input  logic [1:0]        fwd_b,
   input  logic [DATA_W-1:0] alu_out_e,
   input  logic [DATA_W-1:0] mem_out_m,
   input  logic              flush,
   output logic              stall,
   output logic [4:0]        aa,
   output logic [4:0]        ab,
   output logic              valid_e,
   output logic              mem_read_e,
   output logic [4:0]        rd_e,
   output logic [DATA_W-1:0] da_e,
   output logic [DATA_W-1:0] db_e,
   output logic [5:0]        shamt_e,
   output logic [DATA_W-1:0] daddr9_e,
   output logic [DATA_W-1:0] imm12_e,
   output logic [DATA_W-1:0] br_target_e
);

   localparam logic [4:0] XZR = 5'(NUM_REGS - 1);

   // XZR has no storage: entries cover 0..NUM_REGS-2 only.
   logic [DATA_W-1:0] rf [NUM_REGS-1];

   logic [DATA_W-1:0] rf_a, rf_b;
   logic [DATA_W-1:0] rd_a, rd_b;
   logic [DATA_W-1:0] opnd_a, opnd_b;
   logic [5:0]        shamt;
   logic [DATA_W-1:0] daddr9, imm12, br_off, br_target;
   logic              hazard;
   logic              bubble;
   logic              unused_bits;

   assign unused_bits = ^instr_d[31:26];

   assign aa     = instr_d[9:5];
   assign ab     = reg2loc_d ? instr_d[20:16] : instr_d[4:0];
   assign shamt  = instr_d[15:10];
   assign daddr9 = {{(DATA_W-9){instr_d[20]}}, instr_d[20:12]};
   assign imm12  = {{(DATA_W-12){1'b0}}, instr_d[21:10]};
   assign br_off = uncond_br_d ? {{(DATA_W-26){instr_d[25]}}, instr_d[25:0]}
                               : {{(DATA_W-19){instr_d[23]}}, instr_d[23:5]};
   assign br_target = pc_d + (br_off << 2);

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS-1; i++) begin
         if (reset) begin
            rf[i] <= '0;
         end else if (reg_write_w && (rd_w == 5'(i))) begin
            rf[i] <= wdata_w;
         end
      end
   end

   // Addresses at or above XZR match no entry and read as zero.
   always_comb begin
      rf_a = '0;
      rf_b = '0;
      for (int i = 0; i < NUM_REGS-1; i++) begin
         if (aa == 5'(i)) rf_a = rf[i];
         if (ab == 5'(i)) rf_b = rf[i];
      end
   end

`ifdef ID_WRITE_BYPASS_EN
   logic wr_ok;
   assign wr_ok = reg_write_w && (rd_w != XZR) && ({1'b0, rd_w} < 6'(NUM_REGS));
   assign rd_a  = (wr_ok && (rd_w == aa)) ? wdata_w : rf_a;
   assign rd_b  = (wr_ok && (rd_w == ab)) ? wdata_w : rf_b;
`else
   assign rd_a = rf_a;
   assign rd_b = rf_b;
`endif

   always_comb begin
      case (fwd_a)
         2'b01:   opnd_a = alu_out_e;
         2'b10:   opnd_a = mem_out_m;
         default: opnd_a = rd_a;
      endcase
      case (fwd_b)
         2'b01:   opnd_b = alu_out_e;
         2'b10:   opnd_b = mem_out_m;
         default: opnd_b = rd_b;
      endcase
   end

   assign hazard = valid_e & mem_read_e & valid_d & (rd_e != XZR) &
                   ((rd_e == aa) | (rd_e == ab));
   assign stall  = hazard & ~flush & ~reset;
   assign bubble = flush | hazard;

   // Bubble only kills control; data fields hold their previous values.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_e     <= 1'b0;
         mem_read_e  <= 1'b0;
         rd_e        <= '0;
         da_e        <= '0;
         db_e        <= '0;
         shamt_e     <= '0;
         daddr9_e    <= '0;
         imm12_e     <= '0;
         br_target_e <= '0;
      end else if (bubble) begin
         valid_e    <= 1'b0;
         mem_read_e <= 1'b0;
         rd_e       <= XZR;
      end else begin
         valid_e     <= valid_d;
         mem_read_e  <= mem_read_d & valid_d;
         rd_e        <= instr_d[4:0];
         da_e        <= opnd_a;
         db_e        <= opnd_b;
         shamt_e     <= shamt;
         daddr9_e    <= daddr9;
         imm12_e     <= imm12;
         br_target_e <= br_target;
      end
   end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: decode table, directed hazard/forwarding sequences,
// and randomized cycles checked against a cycle-level reference model.
module tb_id_stage_pipelined;

   logic        clk;
   logic        reset;
   logic [31:0] instr_d;
   logic [63:0] pc_d;
   logic        valid_d, reg2loc_d, uncond_br_d, mem_read_d;
   logic        reg_write_w;
   logic [4:0]  rd_w;
   logic [63:0] wdata_w;
   logic [1:0]  fwd_a, fwd_b;
   logic [63:0] alu_out_e, mem_out_m;
   logic        flush;
   logic        stall;
   logic [4:0]  aa, ab;
   logic        valid_e, mem_read_e;
   logic [4:0]  rd_e;
   logic [63:0] da_e, db_e;
   logic [5:0]  shamt_e;
   logic [63:0] daddr9_e, imm12_e, br_target_e;

   int tests  = 0;
   int failed = 0;

   id_stage_pipelined #(.DATA_W(64), .NUM_REGS(32)) dut (
      .clk(clk), .reset(reset), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
      .reg2loc_d(reg2loc_d), .uncond_br_d(uncond_br_d), .mem_read_d(mem_read_d),
      .reg_write_w(reg_write_w), .rd_w(rd_w), .wdata_w(wdata_w),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .alu_out_e(alu_out_e), .mem_out_m(mem_out_m),
      .flush(flush), .stall(stall), .aa(aa), .ab(ab), .valid_e(valid_e),
      .mem_read_e(mem_read_e), .rd_e(rd_e), .da_e(da_e), .db_e(db_e),
      .shamt_e(shamt_e), .daddr9_e(daddr9_e), .imm12_e(imm12_e),
      .br_target_e(br_target_e)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state: architectural registers and the expected ID/EX contents.
   logic [63:0] mrf [32];
   logic        m_valid, m_mr;
   logic [4:0]  m_rd;
   logic [63:0] m_da, m_db, m_daddr, m_imm, m_br;
   logic [5:0]  m_shamt;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
      logic        uncond;
      logic        r2l;
      logic [4:0]  e_aa;
      logic [4:0]  e_ab;
      logic [63:0] e_br;
      logic [5:0]  e_shamt;
      logic [63:0] e_daddr;
      logic [63:0] e_imm;
   } vec_t;
   vec_t vecs [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
      if (v[bits-1]) return v - (64'd1 << bits);
      return v;
   endfunction

   function automatic logic [63:0] rf_read(input logic [4:0] a);
`ifdef ID_WRITE_BYPASS_EN
      if (reg_write_w && rd_w == a && a != 5'd31) return wdata_w;
`endif
      if (a == 5'd31) return 64'd0;
      return mrf[a];
   endfunction

   function automatic logic [63:0] pick(input logic [1:0] sel, input logic [4:0] a);
      if (sel == 2'd1) return alu_out_e;
      if (sel == 2'd2) return mem_out_m;
      return rf_read(a);
   endfunction

   task automatic do_cycle();
      logic [4:0]  ea, eb;
      logic        hz;
      logic [63:0] va, vb, off;
      @(negedge clk);
      ea = instr_d[9:5];
      eb = reg2loc_d ? instr_d[20:16] : instr_d[4:0];
      hz = m_valid && m_mr && valid_d && (m_rd != 5'd31) && (m_rd == ea || m_rd == eb);
      chk("aa", 64'(aa), 64'(ea));
      chk("ab", 64'(ab), 64'(eb));
      chk("stall", 64'(stall), 64'(hz && !flush && !reset));
      va = pick(fwd_a, ea);
      vb = pick(fwd_b, eb);
      off = uncond_br_d ? sext(64'(instr_d[25:0]), 26) : sext(64'(instr_d[23:5]), 19);
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) mrf[i] = 64'd0;
         m_valid = 0; m_mr = 0; m_rd = 0; m_da = 0; m_db = 0;
         m_shamt = 0; m_daddr = 0; m_imm = 0; m_br = 0;
      end else begin
         if (flush || hz) begin
            m_valid = 0; m_mr = 0; m_rd = 5'd31;
         end else begin
            m_valid = valid_d;
            m_mr    = mem_read_d && valid_d;
            m_rd    = instr_d[4:0];
            m_da    = va;
            m_db    = vb;
            m_shamt = instr_d[15:10];
            m_daddr = sext(64'(instr_d[20:12]), 9);
            m_imm   = 64'(instr_d[21:10]);
            m_br    = pc_d + off * 64'd4;
         end
         if (reg_write_w && rd_w != 5'd31) mrf[rd_w] = wdata_w;
      end
      #1;
      chk("valid_e", 64'(valid_e), 64'(m_valid));
      chk("mem_read_e", 64'(mem_read_e), 64'(m_mr));
      chk("rd_e", 64'(rd_e), 64'(m_rd));
      chk("da_e", da_e, m_da);
      chk("db_e", db_e, m_db);
      chk("shamt_e", 64'(shamt_e), 64'(m_shamt));
      chk("daddr9_e", daddr9_e, m_daddr);
      chk("imm12_e", imm12_e, m_imm);
      chk("br_target_e", br_target_e, m_br);
   endtask

   task automatic set_idle();
      instr_d = 0; pc_d = 0; valid_d = 0; reg2loc_d = 0; uncond_br_d = 0;
      mem_read_d = 0; reg_write_w = 0; rd_w = 0; wdata_w = 0; fwd_a = 0; fwd_b = 0;
      alu_out_e = 0; mem_out_m = 0; flush = 0;
   endtask

   function automatic logic [4:0] pick_reg();
      if ($urandom_range(0, 3) == 0) return 5'd31;
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) mrf[i] = 64'd0;
      m_valid = 0; m_mr = 0; m_rd = 0; m_da = 0; m_db = 0;
      m_shamt = 0; m_daddr = 0; m_imm = 0; m_br = 0;

      vecs[0] = '{32'h17FF_FFFF, 64'h100, 1'b1, 1'b0, 5'd31, 5'd31, 64'hFC,
                  6'h3F, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFF};
      vecs[1] = '{32'hB400_0080, 64'h40, 1'b0, 1'b0, 5'd4, 5'd0, 64'h50,
                  6'h00, 64'h0, 64'h0};
      vecs[2] = '{32'h54FF_FFE0, 64'h1000, 1'b0, 1'b0, 5'd31, 5'd0, 64'hFFC,
                  6'h3F, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFF};
      vecs[3] = '{32'h1234_5678, 64'h0, 1'b0, 1'b1, 5'd19, 5'd20, 64'h68ACC,
                  6'h15, 64'hFFFF_FFFF_FFFF_FF45, 64'hD15};

      // Reset held two cycles with random inputs.
      set_idle();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         instr_d = $urandom; pc_d = {$urandom, $urandom}; valid_d = 1'b1;
         mem_read_d = 1'($urandom); reg_write_w = 1'b1; rd_w = 5'($urandom);
         wdata_w = {$urandom, $urandom}; fwd_a = 2'($urandom); fwd_b = 2'($urandom);
         alu_out_e = {$urandom, $urandom}; mem_out_m = {$urandom, $urandom};
         do_cycle();
      end
      chk("reset_valid_e", 64'(valid_e), 64'd0);
      chk("reset_br_target_e", br_target_e, 64'd0);

      reset = 1'b0;
      set_idle();
      valid_d = 1'b1; instr_d = 32'(5 << 5);
      do_cycle();
      chk("x5_after_reset", da_e, 64'd0);

      // Write X3 then read it through operand A.
      set_idle();
      reg_write_w = 1'b1; rd_w = 5'd3; wdata_w = 64'h1234;
      do_cycle();
      set_idle();
      valid_d = 1'b1; instr_d = 32'h8B00_0000 | (3 << 5) | 1;
      do_cycle();
      chk("x3_read", da_e, 64'h1234);
      chk("x3_valid", 64'(valid_e), 64'd1);

      for (int i = 0; i < 4; i++) begin
         set_idle();
         valid_d = 1'b1; instr_d = vecs[i].instr; pc_d = vecs[i].pc;
         uncond_br_d = vecs[i].uncond; reg2loc_d = vecs[i].r2l;
         #1;
         chk("tbl_aa", 64'(aa), 64'(vecs[i].e_aa));
         chk("tbl_ab", 64'(ab), 64'(vecs[i].e_ab));
         do_cycle();
         chk("tbl_br", br_target_e, vecs[i].e_br);
         chk("tbl_shamt", 64'(shamt_e), 64'(vecs[i].e_shamt));
         chk("tbl_daddr9", daddr9_e, vecs[i].e_daddr);
         chk("tbl_imm12", imm12_e, vecs[i].e_imm);
      end

      // Load X7 followed by a consumer of X7: one bubble, then capture.
      set_idle();
      valid_d = 1'b1; mem_read_d = 1'b1; instr_d = 32'hF840_0007;
      do_cycle();
      set_idle();
      valid_d = 1'b1; instr_d = 32'h8B00_0000 | (7 << 5) | 2;
      #1;
      chk("lu_stall", 64'(stall), 64'd1);
      do_cycle();
      chk("lu_bubble_valid", 64'(valid_e), 64'd0);
      chk("lu_bubble_rd", 64'(rd_e), 64'd31);
      #1;
      chk("lu_stall_clear", 64'(stall), 64'd0);
      do_cycle();
      chk("lu_capture_valid", 64'(valid_e), 64'd1);
      chk("lu_capture_rd", 64'(rd_e), 64'd2);

      // Load into XZR never stalls.
      set_idle();
      valid_d = 1'b1; mem_read_d = 1'b1; instr_d = 32'hF840_001F;
      do_cycle();
      set_idle();
      valid_d = 1'b1; instr_d = 32'h8B00_03E2;
      #1;
      chk("xzr_load_no_stall", 64'(stall), 64'd0);
      do_cycle();

      set_idle();
      valid_d = 1'b1; fwd_a = 2'b01; alu_out_e = 64'hAA; fwd_b = 2'b10; mem_out_m = 64'hBB;
      instr_d = 32'h8B01_0020;
      do_cycle();
      chk("fwd_alu", da_e, 64'hAA);
      chk("fwd_mem", db_e, 64'hBB);

      set_idle();
      reg_write_w = 1'b1; rd_w = 5'd31; wdata_w = 64'hDEAD;
      do_cycle();
      set_idle();
      valid_d = 1'b1; instr_d = 32'(31 << 5);
      do_cycle();
      chk("xzr_read", da_e, 64'd0);

      // Flush together with a load-use hazard.
      set_idle();
      valid_d = 1'b1; mem_read_d = 1'b1; instr_d = 32'hF840_0007;
      do_cycle();
      set_idle();
      valid_d = 1'b1; flush = 1'b1; instr_d = 32'h8B00_0000 | (7 << 5) | 2;
      #1;
      chk("flush_stall", 64'(stall), 64'd0);
      do_cycle();
      chk("flush_valid", 64'(valid_e), 64'd0);

`ifdef ID_WRITE_BYPASS_EN
      set_idle();
      valid_d = 1'b1; reg_write_w = 1'b1; rd_w = 5'd9; wdata_w = 64'h77;
      instr_d = 32'(9 << 5);
      do_cycle();
      chk("bypass_x9", da_e, 64'h77);
`endif

      for (int n = 0; n < 400; n++) begin
         reset       = ($urandom_range(0, 49) == 0);
         instr_d     = $urandom;
         instr_d[9:5]   = pick_reg();
         instr_d[4:0]   = pick_reg();
         instr_d[20:16] = pick_reg();
         pc_d        = {$urandom, $urandom};
         valid_d     = ($urandom_range(0, 3) != 0);
         reg2loc_d   = 1'($urandom);
         uncond_br_d = 1'($urandom);
         mem_read_d  = 1'($urandom);
         flush       = ($urandom_range(0, 9) == 0);
         reg_write_w = 1'($urandom);
         rd_w        = pick_reg();
         wdata_w     = {$urandom, $urandom};
         fwd_a       = 2'($urandom);
         fwd_b       = 2'($urandom);
         alu_out_e   = {$urandom, $urandom};
         mem_out_m   = {$urandom, $urandom};
         do_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised instruction-decode stage for the 5-stage ARMv8-subset pipeline.
- Integrates the register file, Reg2Loc operand select, immediate extraction, branch-target adder and EX/MEM forwarding muxes.
- Adds a registered ID/EX pipeline boundary, load-use hazard detection with bubble insertion, and a flush path.
- Sits between the IF/ID register and the execute stage.

Parameters:
- DATA_W, 64: datapath, register and PC width; must be ≥ 28.
- NUM_REGS, 32: architectural registers, 2..32. Register NUM_REGS-1 is the zero register (XZR).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- instr_d  in  32  instruction from IF/ID
- pc_d  in  DATA_W  PC of instr_d
- valid_d  in  1  instr_d is a real instruction
- reg2loc_d  in  1  1: Ab = instr[20:16]; 0: Ab = instr[4:0]
- uncond_br_d  in  1  1: 26-bit branch offset; 0: 19-bit conditional offset
- mem_read_d  in  1  decoded instruction is a load
- reg_write_w  in  1  writeback enable
- rd_w  in  5  writeback address
- wdata_w  in  DATA_W  writeback data
- fwd_a, fwd_b  in  2  operand forwarding selects
- alu_out_e  in  DATA_W  EX-stage result
- mem_out_m  in  DATA_W  MEM-stage result
- flush  in  1  squash the instruction currently in decode
- stall  out  1  hold the PC and IF/ID register this cycle (combinational)
- aa, ab  out  5  decoded read addresses (combinational, for the forwarding unit)
- valid_e, mem_read_e  out  1  registered
- rd_e  out  5  registered
- da_e, db_e  out  DATA_W  registered forwarded operands
- shamt_e  out  6  registered
- daddr9_e, imm12_e, br_target_e  out  DATA_W  registered

Behaviour:
- Reset: every registered output is 0 and every register-file entry is 0, all on the first rising edge with reset high. stall is 0 while reset is high.
- Decode fields (combinational):
  - aa = instr[9:5]; ab per reg2loc_d.
  - shamt = instr[15:10].
  - daddr9 = sign-extend(instr[20:12]); imm12 = zero-extend(instr[21:10]).
  - br_target = pc_d + (sign-extend(uncond_br_d ? instr[25:0] : instr[23:5]) << 2), modulo 2^DATA_W.
- Register file:
  - Two combinational read ports.
  - Write on the rising clk edge when reg_write_w and rd_w != NUM_REGS-1 and rd_w < NUM_REGS.
  - Reads of XZR, or of an address ≥ NUM_REGS, return 0.
  - Writes proceed regardless of stall and flush.
- Forwarding, per operand: 00 = register file, 01 = alu_out_e, 10 = mem_out_m, 11 = register file (reserved).
- Load-use hazard: hazard = valid_e & mem_read_e & valid_d & (rd_e != NUM_REGS-1) & ((rd_e == aa) | (rd_e == ab)).
- stall = hazard & ~flush & ~reset.
- ID/EX register update, priority order:
  1. reset → all zero.
  2. flush or hazard → bubble: valid_e = 0, mem_read_e = 0, rd_e = NUM_REGS-1; other fields don't-care, implemented as hold.
  3. otherwise → capture all decoded fields, forwarded operands, valid_e = valid_d, mem_read_e = mem_read_d & valid_d.
- Latency: 1 cycle from decode inputs to the _e outputs.
- A stalled instruction re-decodes on the next cycle. The bubble clears the hazard, so a stall lasts exactly 1 cycle per load.
- Flush and hazard in the same cycle: treated as flush, stall = 0.
- Reset mid-stall: the bubble is discarded and stall drops in the same cycle reset is sampled.

Optional Feature:
- Macro: ID_WRITE_BYPASS_EN.
- Defined: when reg_write_w and rd_w == aa (resp. ab), rd_w != XZR and the forward select is 00/11, the operand takes wdata_w in the same cycle (write-before-read).
- Undefined: the operand comes from the stored register-file value; the hazard unit must forward instead.

Test Plan:
- Reset held 2 cycles with random inputs → every _e output is 0 and stall = 0. After release, reading X5 gives 0.
- Write X3 = 0x1234 (rd_w = 3, reg_write_w = 1); next cycle decode ADD with Rn = 3, fwd_a = 00 → da_e = 0x1234 one cycle later, valid_e = 1.
- B instruction with imm26 = 0x3FFFFFF, pc_d = 0x100, uncond_br_d = 1 → br_target_e = 0xFC. CBZ with imm19 = 4, pc_d = 0x40, uncond_br_d = 0 → br_target_e = 0x50.
- Load writing X7 in EX (valid_e = mem_read_e = 1, rd_e = 7), decode reads X7 → stall = 1 for one cycle and valid_e = 0 next cycle; the held instruction is then captured with valid_e = 1. With rd_e = 31, stall = 0.
- fwd_a = 01 with alu_out_e = 0xAA → da_e = 0xAA. fwd_b = 10 with mem_out_m = 0xBB → db_e = 0xBB. Write to X31 followed by a read → 0.
- flush = 1 together with a hazard → stall = 0, valid_e = 0. With ID_WRITE_BYPASS_EN defined, same-cycle write X9 = 0x77 and read X9 → da_e = 0x77.
